// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types for the SIMON decryptor arbiter
package simon_pkg;

    localparam int SIMON_BUS_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        DATA,
        WAIT
    } arb_state_e;

    typedef struct packed {
        logic [SIMON_BUS_W-1:0] data;
        logic [SIMON_BUS_W-1:0] key;
        logic                   key_upd;
    } simon_req_t;

endpackage

// File: rtl/simon_rr_arb2.sv
// rtl/simon_rr_arb2.sv - two-way round-robin grant with a one-bit priority pointer
module simon_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic rr_ptr;

    // The pointer only matters when both requesters contend.
    always_comb begin
        gnt_idx = (req[0] && req[1]) ? rr_ptr : req[1];
        gnt     = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt != 2'b00) begin
            rr_ptr <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/simon_dec_arb.sv
// rtl/simon_dec_arb.sv - two-requester arbiter and sequencer in front of one SIMON decryptor
module simon_dec_arb
    import simon_pkg::*;
#(
    parameter bit          KEY_CACHE_EN   = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIMON_BUS_W-1:0] req0_data,
    input  logic [SIMON_BUS_W-1:0] req1_data,
    input  logic [SIMON_BUS_W-1:0] req0_key,
    input  logic [SIMON_BUS_W-1:0] req1_key,
    input  logic                   req0_key_upd,
    input  logic                   req1_key_upd,
    input  logic                   req0_vld,
    input  logic                   req1_vld,
    output logic                   req0_rdy,
    output logic                   req1_rdy,
    output logic [SIMON_BUS_W-1:0] rsp0_data,
    output logic [SIMON_BUS_W-1:0] rsp1_data,
    output logic                   rsp0_vld,
    output logic                   rsp1_vld,
    input  logic                   rsp0_rdy,
    input  logic                   rsp1_rdy,
    output logic [SIMON_BUS_W-1:0] dec_data_in,
    output logic                   dec_data_in_vld,
    input  logic                   dec_data_in_rdy,
    output logic [SIMON_BUS_W-1:0] dec_key_in,
    output logic                   dec_key_in_vld,
    input  logic                   dec_key_in_rdy,
    input  logic [SIMON_BUS_W-1:0] dec_data_out,
    input  logic                   dec_data_out_vld,
    output logic                   dec_data_out_rdy,
    output logic                   timeout_err
);

    arb_state_e             state, state_nx;
    logic [SIMON_BUS_W-1:0] hold_data, hold_key;
    logic [SIMON_BUS_W-1:0] rsp0_hold, rsp1_hold;
    logic                   owner, key_valid, key_owner, drain_en;
    logic [31:0]            wait_cnt;
    logic [1:0]             gnt;
    logic                   gnt_idx;
    simon_req_t             sel_req;
    logic                   need_key, timeout_hit;

    simon_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_vld, req0_vld}),
        .en      (state == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req0_rdy    = gnt[0];
    assign req1_rdy    = gnt[1];
    assign dec_data_in = hold_data;
    assign dec_key_in  = hold_key;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1);

    // Outside the delivery cycle each port shows the last plaintext it accepted.
    assign rsp0_data = rsp0_vld ? dec_data_out : rsp0_hold;
    assign rsp1_data = rsp1_vld ? dec_data_out : rsp1_hold;

    always_comb begin
        if (gnt_idx) begin
            sel_req = '{data: req1_data, key: req1_key, key_upd: req1_key_upd};
        end else begin
            sel_req = '{data: req0_data, key: req0_key, key_upd: req0_key_upd};
        end
        need_key = !KEY_CACHE_EN || !key_valid || (key_owner != gnt_idx) || sel_req.key_upd;
    end

    always_comb begin
        state_nx         = state;
        dec_key_in_vld   = 1'b0;
        dec_data_in_vld  = 1'b0;
        dec_data_out_rdy = 1'b0;
        rsp0_vld         = 1'b0;
        rsp1_vld         = 1'b0;
        timeout_err      = 1'b0;
        case (state)
            IDLE: begin
                // Only after an abort can a stale result still be in flight.
                dec_data_out_rdy = drain_en;
                if (gnt != 2'b00) begin
                    state_nx = need_key ? KEY : DATA;
                end
            end
            KEY: begin
                dec_key_in_vld = 1'b1;
                if (dec_key_in_rdy) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                dec_data_in_vld = 1'b1;
                if (dec_data_in_rdy) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                rsp0_vld         = !owner && dec_data_out_vld;
                rsp1_vld         = owner && dec_data_out_vld;
                dec_data_out_rdy = owner ? rsp1_rdy : rsp0_rdy;
                if (dec_data_out_vld && dec_data_out_rdy) begin
                    state_nx = IDLE;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_key  <= '0;
            owner     <= 1'b0;
            key_valid <= 1'b0;
            key_owner <= 1'b0;
            drain_en  <= 1'b0;
            wait_cnt  <= '0;
            rsp0_hold <= '0;
            rsp1_hold <= '0;
        end else begin
            state <= state_nx;
            if (gnt != 2'b00) begin
                hold_data <= sel_req.data;
                hold_key  <= sel_req.key;
                owner     <= gnt_idx;
            end
            if (state == KEY && dec_key_in_rdy) begin
                key_valid <= 1'b1;
                key_owner <= owner;
            end
            if (state == DATA && dec_data_in_rdy) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (rsp0_vld && rsp0_rdy) begin
                rsp0_hold <= dec_data_out;
            end
            if (rsp1_vld && rsp1_rdy) begin
                rsp1_hold <= dec_data_out;
            end
            // The aborted job may have left the decryptor holding a key we no longer trust.
            if (timeout_err) begin
                key_valid <= 1'b0;
                drain_en  <= 1'b1;
            end else if (state == IDLE && drain_en && dec_data_out_vld) begin
                drain_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_dec_arb.sv
// tb/tb_simon_dec_arb.sv - directed bench for simon_dec_arb with a behavioural decryptor
module tb_simon_dec_arb;

    localparam logic [255:0] K_S  = 256'h1918111009080100;
    localparam logic [255:0] D_S  = 256'hc69be9bb;
    localparam logic [255:0] E_S  = 256'h65656877;
    localparam logic [255:0] K_W  = {8'hC3, 248'h0};
    localparam logic [255:0] D_W  = {8'h3C, 216'h0, 32'hc69be9bb};
    localparam logic [255:0] E_W  = {8'hFF, 216'h0, 32'hc69be9bb};
    localparam logic [255:0] D_W2 = {8'h01, 248'h0};
    localparam logic [255:0] E_W2 = {8'hC2, 248'h0};

    typedef struct {
        int           r;
        logic [255:0] key;
        logic [255:0] data;
        logic         upd;
        logic [255:0] exp;
        int           kd;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] req_data [2][2];
    logic [255:0] req_key  [2][2];
    logic [255:0] rsp_data [2][2];
    logic         req_upd  [2][2];
    logic         req_vld  [2][2];
    logic         req_rdy  [2][2];
    logic         rsp_vld  [2][2];
    logic         rsp_rdy  [2][2];
    logic [255:0] dec_din [2];
    logic [255:0] dec_kin [2];
    logic [255:0] dec_dout [2];
    logic         dec_din_vld [2];
    logic         dec_din_rdy [2];
    logic         dec_kin_vld [2];
    logic         dec_kin_rdy [2];
    logic         dec_dout_vld [2];
    logic         dec_dout_rdy [2];
    logic         terr [2];
    logic         stall [2];

    logic [255:0] m_key [2];
    logic [255:0] m_data [2];
    logic         m_busy [2];
    int           m_cnt [2];
    int           key_loads [2] = '{0, 0};
    int           data_loads [2] = '{0, 0};

    int errors = 0;
    int checks = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    simon_dec_arb dut0 (
        .clk(clk), .rst(rst),
        .req0_data(req_data[0][0]), .req1_data(req_data[0][1]),
        .req0_key(req_key[0][0]), .req1_key(req_key[0][1]),
        .req0_key_upd(req_upd[0][0]), .req1_key_upd(req_upd[0][1]),
        .req0_vld(req_vld[0][0]), .req1_vld(req_vld[0][1]),
        .req0_rdy(req_rdy[0][0]), .req1_rdy(req_rdy[0][1]),
        .rsp0_data(rsp_data[0][0]), .rsp1_data(rsp_data[0][1]),
        .rsp0_vld(rsp_vld[0][0]), .rsp1_vld(rsp_vld[0][1]),
        .rsp0_rdy(rsp_rdy[0][0]), .rsp1_rdy(rsp_rdy[0][1]),
        .dec_data_in(dec_din[0]), .dec_data_in_vld(dec_din_vld[0]), .dec_data_in_rdy(dec_din_rdy[0]),
        .dec_key_in(dec_kin[0]), .dec_key_in_vld(dec_kin_vld[0]), .dec_key_in_rdy(dec_kin_rdy[0]),
        .dec_data_out(dec_dout[0]), .dec_data_out_vld(dec_dout_vld[0]), .dec_data_out_rdy(dec_dout_rdy[0]),
        .timeout_err(terr[0])
    );

    simon_dec_arb #(.TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst),
        .req0_data(req_data[1][0]), .req1_data(req_data[1][1]),
        .req0_key(req_key[1][0]), .req1_key(req_key[1][1]),
        .req0_key_upd(req_upd[1][0]), .req1_key_upd(req_upd[1][1]),
        .req0_vld(req_vld[1][0]), .req1_vld(req_vld[1][1]),
        .req0_rdy(req_rdy[1][0]), .req1_rdy(req_rdy[1][1]),
        .rsp0_data(rsp_data[1][0]), .rsp1_data(rsp_data[1][1]),
        .rsp0_vld(rsp_vld[1][0]), .rsp1_vld(rsp_vld[1][1]),
        .rsp0_rdy(rsp_rdy[1][0]), .rsp1_rdy(rsp_rdy[1][1]),
        .dec_data_in(dec_din[1]), .dec_data_in_vld(dec_din_vld[1]), .dec_data_in_rdy(dec_din_rdy[1]),
        .dec_key_in(dec_kin[1]), .dec_key_in_vld(dec_kin_vld[1]), .dec_key_in_rdy(dec_kin_rdy[1]),
        .dec_data_out(dec_dout[1]), .dec_data_out_vld(dec_dout_vld[1]), .dec_data_out_rdy(dec_dout_rdy[1]),
        .timeout_err(terr[1])
    );

    // Stand-in decryptor: the known SIMON32/64 vector, otherwise data xor resident key.
    function automatic logic [255:0] dec_fn(input logic [255:0] k, input logic [255:0] d);
        if (k[63:0] == 64'h1918111009080100 && d[31:0] == 32'hc69be9bb)
            return {d[255:32], 32'h65656877};
        return d ^ k;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                m_busy[g]       <= 1'b0;
                m_cnt[g]        <= 0;
                m_key[g]        <= '0;
                m_data[g]       <= '0;
                dec_dout_vld[g] <= 1'b0;
                dec_dout[g]     <= '0;
            end else begin
                if (dec_kin_vld[g] && dec_kin_rdy[g]) begin
                    m_key[g]     <= dec_kin[g];
                    key_loads[g] <= key_loads[g] + 1;
                end
                if (dec_din_vld[g] && dec_din_rdy[g]) begin
                    m_data[g]     <= dec_din[g];
                    m_busy[g]     <= 1'b1;
                    m_cnt[g]      <= 3;
                    data_loads[g] <= data_loads[g] + 1;
                end else if (m_busy[g] && !dec_dout_vld[g]) begin
                    if (m_cnt[g] > 0) m_cnt[g] <= m_cnt[g] - 1;
                    else if (!stall[g]) begin
                        dec_dout_vld[g] <= 1'b1;
                        dec_dout[g]     <= dec_fn(m_key[g], m_data[g]);
                    end
                end
                if (dec_dout_vld[g] && dec_dout_rdy[g]) begin
                    dec_dout_vld[g] <= 1'b0;
                    m_busy[g]       <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_req(input int g, input int r, input logic [255:0] k, input logic [255:0] d,
                            input logic u);
        int n = 0;
        @(negedge clk);
        req_key[g][r] = k; req_data[g][r] = d; req_upd[g][r] = u; req_vld[g][r] = 1'b1;
        #1;
        while (!req_rdy[g][r] && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check($sformatf("grant i%0d r%0d", g, r), req_rdy[g][r], 1);
        @(negedge clk);
        req_vld[g][r] = 1'b0;
    endtask

    task automatic wait_rsp(input int g, input int r, output logic [255:0] got, output logic other);
        int n = 0;
        other = 1'b0;
        #1;
        while (!rsp_vld[g][r] && n < 200) begin
            if (rsp_vld[g][1-r]) other = 1'b1;
            @(negedge clk); #1; n++;
        end
        check($sformatf("rsp_vld i%0d r%0d", g, r), rsp_vld[g][r], 1);
        got = rsp_data[g][r];
    endtask

    task automatic run_job(input int g, input int r, input logic [255:0] k, input logic [255:0] d,
                           input logic u, output logic [255:0] got, output logic other);
        send_req(g, r, k, d, u);
        wait_rsp(g, r, got, other);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string name, input int g);
        check({name, " ctl"}, {req_rdy[g][0], req_rdy[g][1], rsp_vld[g][0], rsp_vld[g][1],
              dec_din_vld[g], dec_kin_vld[g], dec_dout_rdy[g], terr[g]}, 0);
    endtask

    initial begin
        logic [255:0] got, got0, got1;
        logic         oth, drop1, stable_ok, rsp_seen;
        int           kl, dl, n, seq, nresp, first_terr, nterr;

        vecs[0] = '{0, K_S, D_S, 1'b0, E_S, 1};
        vecs[1] = '{0, K_S, D_S, 1'b0, E_S, 0};
        vecs[2] = '{1, 256'hA5A5, 256'h0F0F, 1'b0, 256'hAAAA, 1};
        vecs[3] = '{1, 256'hA5A5, 256'h1234, 1'b0, 256'hB791, 0};
        vecs[4] = '{1, 256'h00FF, 256'h0F0F, 1'b1, 256'h0FF0, 1};
        vecs[5] = '{0, K_S, D_S, 1'b0, E_S, 1};
        vecs[6] = '{0, K_W, D_W, 1'b1, E_W, 1};
        vecs[7] = '{0, K_W, D_W2, 1'b0, E_W2, 0};

        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            stall[g] = 1'b0; dec_din_rdy[g] = 1'b1; dec_kin_rdy[g] = 1'b1;
            for (int r = 0; r < 2; r++) begin
                req_vld[g][r] = 1'b0; req_upd[g][r] = 1'b0; rsp_rdy[g][r] = 1'b1;
                req_data[g][r] = '0; req_key[g][r] = '0;
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check_quiet($sformatf("reset i%0d", g), g);
            check($sformatf("reset rsp_data i%0d", g), rsp_data[g][0] | rsp_data[g][1], 0);
            check($sformatf("reset hold i%0d", g), dec_din[g] | dec_kin[g], 0);
        end

        for (int i = 0; i < 8; i++) begin
            kl = key_loads[0]; dl = data_loads[0];
            run_job(0, vecs[i].r, vecs[i].key, vecs[i].data, vecs[i].upd, got, oth);
            check($sformatf("v%0d data", i), got, vecs[i].exp);
            check($sformatf("v%0d key_loads", i), 256'(key_loads[0] - kl), 256'(vecs[i].kd));
            check($sformatf("v%0d data_loads", i), 256'(data_loads[0] - dl), 1);
            check($sformatf("v%0d other_rsp", i), oth, 0);
        end

        // Contention straight after reset: requester 0 first, then requester 1.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        kl = key_loads[0];
        req_key[0][0] = 256'h00FF; req_data[0][0] = 256'h0F00; req_upd[0][0] = 1'b0;
        req_key[0][1] = 256'hF000; req_data[0][1] = 256'h0F00; req_upd[0][1] = 1'b0;
        req_vld[0][0] = 1'b1; req_vld[0][1] = 1'b1;
        #1;
        check("both rdy0", req_rdy[0][0], 1);
        check("both rdy1", req_rdy[0][1], 0);
        @(negedge clk); req_vld[0][0] = 1'b0;
        n = 0; seq = 0; nresp = 0; drop1 = 1'b0; got0 = '0; got1 = '0;
        while (nresp < 2 && n < 300) begin
            #1;
            if (req_rdy[0][1]) drop1 = 1'b1;
            if (rsp_vld[0][0]) begin seq = seq * 10 + 1; nresp++; got0 = rsp_data[0][0]; end
            if (rsp_vld[0][1]) begin seq = seq * 10 + 2; nresp++; got1 = rsp_data[0][1]; end
            @(negedge clk);
            if (drop1) req_vld[0][1] = 1'b0;
            n++;
        end
        check("both order", 256'(seq), 12);
        check("both data0", got0, 256'h0FFF);
        check("both data1", got1, 256'hFF00);
        check("both key_loads", 256'(key_loads[0] - kl), 2);

        // Requester 0 withholds rsp_rdy for 20 cycles while the result is presented.
        rsp_rdy[0][0] = 1'b0;
        send_req(0, 0, 256'h00FF, 256'h0001, 1'b0);
        wait_rsp(0, 0, got, oth);
        check("stall data", got, 256'h00FE);
        stable_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (dec_dout_rdy[0] || !rsp_vld[0][0] || rsp_data[0][0] !== got) stable_ok = 1'b0;
        end
        check("stall stable", stable_ok, 1);
        @(negedge clk);
        rsp_rdy[0][0] = 1'b1;
        #1;
        check("stall release rdy", dec_dout_rdy[0], 1);
        @(negedge clk); #1;
        check("stall done vld", rsp_vld[0][0], 0);
        check("stall held data", rsp_data[0][0], 256'h00FE);

        // Timeout on the 16-cycle instance with the decryptor stalled.
        kl = key_loads[1];
        run_job(1, 0, 256'hAB00, 256'h00CD, 1'b0, got, oth);
        check("to warm data", got, 256'hABCD);
        stall[1] = 1'b1;
        kl = key_loads[1];
        send_req(1, 0, 256'hAB00, 256'h0011, 1'b0);
        #1; n = 0;
        while (!dec_din_vld[1] && n < 50) begin @(negedge clk); #1; n++; end
        check("to data issued", dec_din_vld[1], 1);
        check("to cached key", 256'(key_loads[1] - kl), 0);
        first_terr = 0; nterr = 0; rsp_seen = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk); #1;
            if (terr[1]) begin nterr++; if (first_terr == 0) first_terr = k; end
            if (rsp_vld[1][0] || rsp_vld[1][1]) rsp_seen = 1'b1;
        end
        check("to first pulse", 256'(first_terr), 16);
        check("to pulse count", 256'(nterr), 1);
        check("to drain rdy", dec_dout_rdy[1], 1);
        stall[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (rsp_vld[1][0] || rsp_vld[1][1]) rsp_seen = 1'b1;
        end
        check("to no response", rsp_seen, 0);
        check("to late drained", dec_dout_vld[1], 0);
        kl = key_loads[1];
        run_job(1, 0, 256'hAB00, 256'h0022, 1'b0, got, oth);
        check("to next data", got, 256'hAB22);
        check("to next key_load", 256'(key_loads[1] - kl), 1);

        // Reset while parked in KEY.
        dec_kin_rdy[0] = 1'b0;
        send_req(0, 1, 256'h5500, 256'h0055, 1'b0);
        #1;
        check("rst in key", dec_kin_vld[0], 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check_quiet("rst mid", 0);
        dec_kin_rdy[0] = 1'b1;
        kl = key_loads[0];
        run_job(0, 1, 256'h5500, 256'h0055, 1'b0, got, oth);
        check("rst next data", got, 256'h5555);
        check("rst next key_load", 256'(key_loads[0] - kl), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
